mdu_iterative: RTL and testbench



---
 rtl/mdu_iterative_pkg.sv | 16 +
 rtl/mdu_sign_fix.sv | 20 ++
 rtl/mdu_iterative.sv | 131 +++++++++++++
 tb/tb_mdu_iterative.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mdu_iterative_pkg.sv
// mdu_iterative_pkg: op codes and FSM states shared by the multiply/divide unit and its users.
package mdu_iterative_pkg;
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } mdu_state_e;
endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: conditional two's-complement negate, either per WIDTH half or over the full 2xWIDTH value.
module mdu_sign_fix
  import mdu_iterative_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               i_split,
  input  logic               i_neg_hi,
  input  logic               i_neg_lo,
  input  logic [2*WIDTH-1:0] i_val,
  output logic [2*WIDTH-1:0] o_val
);
  logic [WIDTH-1:0]   w_hi;
  logic [WIDTH-1:0]   w_lo;
  logic [2*WIDTH-1:0] w_full;
  assign w_hi   = i_neg_hi ? -i_val[2*WIDTH-1:WIDTH] : i_val[2*WIDTH-1:WIDTH];
  assign w_lo   = i_neg_lo ? -i_val[WIDTH-1:0] : i_val[WIDTH-1:0];
  assign w_full = i_neg_lo ? -i_val : i_val;
  assign o_val  = i_split ? {w_hi, w_lo} : w_full;
endmodule

// File: rtl/mdu_iterative.sv
// mdu_iterative: radix-2 sequential multiply/divide unit owning HI/LO.
module mdu_iterative
  import mdu_iterative_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_x,
  input  logic [WIDTH-1:0] op_y,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  mdu_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_x;
  logic               r_div;
  logic               r_zero;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_done;
  logic               r_dz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               w_signed;
  logic               w_sx;
  logic               w_sy;
  logic [2*WIDTH-1:0] w_abs;
  logic [2*WIDTH-1:0] w_fix;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_nx;
  assign w_signed = ~op[0] & ~op[2];
  assign w_sx     = w_signed & op_x[WIDTH-1];
  assign w_sy     = w_signed & op_y[WIDTH-1];
  // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
  assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  // Divide: restoring step; remainder always fits WIDTH bits after a successful subtract.
  assign w_shift  = {r_rem, r_acc[WIDTH-1]};
  assign w_ge     = w_shift >= {1'b0, r_b};
  assign w_rem_nx = w_ge ? w_shift[WIDTH-1:0] - r_b : w_shift[WIDTH-1:0];
  mdu_sign_fix #(.WIDTH(WIDTH)) u_abs (
    .i_split (1'b1),
    .i_neg_hi(w_sx),
    .i_neg_lo(w_sy),
    .i_val   ({op_x, op_y}),
    .o_val   (w_abs)
  );
  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix (
    .i_split (r_div),
    .i_neg_hi(r_neg_rem),
    .i_neg_lo(r_neg_res),
    .i_val   (r_div ? {r_rem, r_acc[WIDTH-1:0]} : r_acc),
    .o_val   (w_fix)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_b       <= '0;
      r_x       <= '0;
      r_div     <= 1'b0;
      r_zero    <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush) r_state <= S_IDLE;
      else
        case (r_state)
          S_IDLE:
            if (start) begin
              if (op == MDU_MTHI) begin
                r_hi   <= op_x;
                r_done <= 1'b1;
              end else if (op == MDU_MTLO) begin
                r_lo   <= op_x;
                r_done <= 1'b1;
              end else if (!op[2]) begin
                r_div     <= op[1];
                r_zero    <= op_y == '0;
                r_x       <= op_x;
                r_neg_res <= w_sx ^ w_sy;
                r_neg_rem <= w_sx;
                r_b       <= op[1] ? w_abs[WIDTH-1:0] : w_abs[2*WIDTH-1:WIDTH];
                r_acc     <= {{WIDTH{1'b0}}, op[1] ? w_abs[2*WIDTH-1:WIDTH] : w_abs[WIDTH-1:0]};
                r_rem     <= '0;
                r_cnt     <= '0;
                r_state   <= S_RUN;
              end
            end
          S_RUN: begin
            r_acc <= r_div ? {{WIDTH{1'b0}}, r_acc[WIDTH-2:0], w_ge} : {w_sum, r_acc[WIDTH-1:1]};
            r_rem <= w_rem_nx;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= S_FIX;
          end
          S_FIX: begin
            r_hi    <= (r_div & r_zero) ? r_x : w_fix[2*WIDTH-1:WIDTH];
            r_lo    <= (r_div & r_zero) ? '1 : w_fix[WIDTH-1:0];
            r_dz    <= r_div ? r_zero : r_dz;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
    end
  end
  assign busy     = r_state != S_IDLE;
  assign done     = r_done;
  assign div_zero = r_dz;
  assign hi       = r_hi;
  assign lo       = r_lo;
endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: directed vector table plus hand sequences for flush, reset and ignored requests.
module tb_mdu_iterative;
  import mdu_iterative_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] op_x = '0;
  logic [31:0] op_y = '0;
  logic        flush = 1'b0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;
  vec_t tv[14];
  mdu_iterative #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .op_x(op_x), .op_y(op_y),
    .flush(flush), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; op_x = x; op_y = y;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    for (int k = 1; k <= 60; k++) begin
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask
  initial begin
    int lat, bcnt, nd;
    logic [31:0] sv_hi, sv_lo;
    tv[0]  = '{MDU_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    tv[1]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    tv[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tv[3]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    tv[4]  = '{MDU_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1};
    tv[5]  = '{MDU_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    tv[6]  = '{MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    tv[7]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    tv[8]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    tv[9]  = '{MDU_MULT,  32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, 1'b1};
    tv[10] = '{MDU_MTHI,  32'h12345678, 32'h00000000, 32'h12345678, 32'h0000002A, 1'b1};
    tv[11] = '{MDU_MTLO,  32'h000000A5, 32'h00000000, 32'h12345678, 32'h000000A5, 1'b1};
    tv[12] = '{MDU_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    tv[13] = '{MDU_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    repeat (2) @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset div_zero", {31'b0, div_zero}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      issue(tv[i].op, tv[i].x, tv[i].y);
      wait_done(lat, bcnt);
      chk($sformatf("vec%0d latency", i), lat, tv[i].op[2] ? 32'd1 : 32'd34);
      chk($sformatf("vec%0d busy cycles", i), bcnt, tv[i].op[2] ? 32'd0 : 32'd33);
      chk($sformatf("vec%0d hi", i), hi, tv[i].hi);
      chk($sformatf("vec%0d lo", i), lo, tv[i].lo);
      chk($sformatf("vec%0d div_zero", i), {31'b0, div_zero}, {31'b0, tv[i].dz});
      @(negedge clk);
      chk($sformatf("vec%0d done pulse", i), {31'b0, done}, 32'd0);
    end
    // reserved op is ignored
    sv_hi = hi; sv_lo = lo;
    issue(3'd6, 32'hCAFEF00D, 32'd1);
    nd = 0;
    repeat (5) begin
      if (done || busy) nd++;
      @(negedge clk);
    end
    chk("reserved no activity", nd, 32'd0);
    chk("reserved lo", lo, sv_lo);
    // flush in IDLE suppresses a same-cycle start
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = MDU_MTLO; op_x = 32'h0BADBEEF;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("idle flush done", {31'b0, done}, 32'd0);
    chk("idle flush lo", lo, sv_lo);
    // MTHI, then flushed MULT with an ignored start while busy
    issue(MDU_MTHI, 32'h12345678, 32'd0);
    wait_done(lat, bcnt);
    chk("mthi latency", lat, 32'd1);
    sv_lo = lo;
    issue(MDU_MULT, 32'd6, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; op = MDU_MTLO; op_x = 32'h0000DEAD;
    @(negedge clk);
    start = 1'b0;
    chk("busy during run", {31'b0, busy}, 32'd1);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", {31'b0, busy}, 32'd0);
    nd = 0;
    repeat (40) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("flush no done", nd, 32'd0);
    chk("flush hi", hi, 32'h12345678);
    chk("flush lo", lo, sv_lo);
    // flush on the FIX exit edge drops the write
    issue(MDU_MULT, 32'd3, 32'd3);
    repeat (32) @(negedge clk);
    chk("fix busy", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fix flush done", {31'b0, done}, 32'd0);
    chk("fix flush busy", {31'b0, busy}, 32'd0);
    chk("fix flush hi", hi, 32'h12345678);
    chk("fix flush lo", lo, sv_lo);
    // reset mid-divide, then MTLO
    issue(MDU_DIV, 32'd100, 32'd3);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    nd = 0;
    repeat (40) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("rst no done", nd, 32'd0);
    issue(MDU_MTLO, 32'h000000A5, 32'd0);
    wait_done(lat, bcnt);
    chk("mtlo latency", lat, 32'd1);
    chk("mtlo lo", lo, 32'h000000A5);
    chk("mtlo hi", hi, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
